// File: rtl/uart_pkg.sv
// uart_pkg: shared arbiter state type and UART width/timeout defaults
package uart_pkg;

    localparam int UART_DATA_W     = 8;
    localparam int TIMEOUT_CYC_DEF = 64;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE
    } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester and UART transmit signals shared by the arbiter
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
);
    localparam int IW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        ack;
    logic [NUM_REQ-1:0]        done;
    logic                      tx_start;
    logic [DATA_W-1:0]         tx_data;
    logic                      tx_busy;
    logic [IW-1:0]             grant_id;
    logic                      arb_busy;
    logic                      err;

    modport master (
        output req, req_data, tx_busy,
        input  ack, done, tx_start, tx_data, grant_id, arb_busy, err
    );

    modport slave (
        input  req, req_data, tx_busy,
        output ack, done, tx_start, tx_data, grant_id, arb_busy, err
    );

endinterface

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin selector, first pending index at or after ptr wins
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IW-1:0]      idx,
    output logic               any
);
    logic [IW:0] pos;
    logic        hit;

    // Scan upward from ptr with wrap; the first pending requester is granted
    always_comb begin
        gnt = '0;
        idx = '0;
        hit = 1'b0;
        pos = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pos = {1'b0, ptr} + (IW + 1)'(i);
            if (pos >= (IW + 1)'(NUM_REQ)) pos = pos - (IW + 1)'(NUM_REQ);
            if (!hit && req[pos[IW-1:0]]) begin
                hit = 1'b1;
                idx = pos[IW-1:0];
                gnt[pos[IW-1:0]] = 1'b1;
            end
        end
    end

    assign any = hit;

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter among NUM_REQ producers
// Optional feature: define UART_ARB_TIMEOUT_EN to abort frames whose tx_busy never rises.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = UART_DATA_W,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input logic               clk,
    input logic               rst,
    uart_tx_arbiter_if.slave  bus
);
    localparam int IW = $clog2(NUM_REQ);

    arb_state_t         state_q, state_d;
    logic [IW-1:0]      ptr_q, ptr_d;
    logic [IW-1:0]      grant_q, grant_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic               tx_start_q, tx_start_d;
    logic [DATA_W-1:0]  tx_data_q, tx_data_d;
    logic               arb_busy_q, arb_busy_d;
    logic               err_d;

    logic [NUM_REQ-1:0] pick_gnt;
    logic [IW-1:0]      pick_idx;
    logic               pick_any;

    rr_pick #(.NUM_REQ(NUM_REQ), .IW(IW)) u_pick (
        .req (bus.req),
        .ptr (ptr_q),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYC != 0);
`endif

    // Next-state and next-output computation; every output is taken from a flop
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        grant_d    = grant_q;
        ack_d      = '0;
        done_d     = '0;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        err_d      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pick_any && !bus.tx_busy) begin
                    state_d    = ISSUE;
                    grant_d    = pick_idx;
                    ack_d      = pick_gnt;
                    tx_start_d = 1'b1;
                    tx_data_d  = bus.req_data[pick_idx*DATA_W +: DATA_W];
                end
            end
            ISSUE: begin
                state_d = WAIT_BUSY;
                ptr_d   = (grant_q == IW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
            end
            WAIT_BUSY: begin
                if (bus.tx_busy) begin
                    state_d = WAIT_DONE;
`ifdef UART_ARB_TIMEOUT_EN
                end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
`endif
                end
            end
            WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    state_d = IDLE;
                    done_d  = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_q;
                end
            end
            default: state_d = IDLE;
        endcase
        arb_busy_d = (state_d != IDLE);
    end

    // State and output registers; reset abandons any frame without a done pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            grant_q    <= '0;
            ack_q      <= '0;
            done_q     <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
            arb_busy_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            grant_q    <= grant_d;
            ack_q      <= ack_d;
            done_q     <= done_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            arb_busy_q <= arb_busy_d;
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    // Count cycles spent in WAIT_BUSY; cleared whenever another state is entered
    always_comb begin
        cnt_d = (state_q == WAIT_BUSY && state_d == WAIT_BUSY) ? cnt_q + 1'b1 : '0;
    end

    // Timeout counter and registered error pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = err_d;
`endif

    assign bus.ack      = ack_q;
    assign bus.done     = done_q;
    assign bus.tx_start = tx_start_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.grant_id = grant_q;
    assign bus.arb_busy = arb_busy_q;

endmodule
